// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: CPU-wide basic types shared across pipeline stages.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: MEM-stage controller state, request record and defaults.
package diaosi_types_pkg;
  import cpu_types_pkg::*;
  localparam int unsigned MEMCTL_TIMEOUT_DEFAULT = 255;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} memctl_state_t;
  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } mem_req_t;
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: REQ-cycle counter; tc fires in the LIMIT-th counted cycle.
module mem_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK) begin
    if (RST || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign tc = en && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data cache request controller with stall, halt and conflict tracking.
// Define MEM_ACCESS_TIMEOUT_EN to abort requests stuck in REQ for TIMEOUT_CYCLES cycles.
module mem_access_ctrl
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = MEMCTL_TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              d_ren_i,
  input  logic              d_wen_i,
  input  logic [ADDR_W-1:0] dmemaddr_i,
  input  logic [DATA_W-1:0] dmemstore_i,
  input  logic              halt_i,
  input  logic              pipe_adv_i,
  input  logic              dhit_i,
  input  logic [DATA_W-1:0] dmemload_i,
  output logic              dmemREN_o,
  output logic              dmemWEN_o,
  output logic [ADDR_W-1:0] dmemaddr_o,
  output logic [DATA_W-1:0] dmemstore_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              mem_stall_o,
  output logic              halted_o,
  output logic              conflict_o,
  output logic              timeout_o
);
  memctl_state_t state_q, state_d;
  mem_req_t      req_q;
  logic          pending, tc;
  assign pending     = (d_ren_i | d_wen_i) & ~halted_o;
  assign dmemREN_o   = req_q.ren;
  assign dmemWEN_o   = req_q.wen;
  assign dmemaddr_o  = ADDR_W'(req_q.addr);
  assign dmemstore_o = DATA_W'(req_q.store);
`ifdef MEM_ACCESS_TIMEOUT_EN
  mem_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .CLK (CLK),
    .RST (RST),
    .clr (state_q != REQ),
    .en  (state_q == REQ && !dhit_i),
    .tc  (tc)
  );
`else
  assign tc = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif
  always_comb begin
    state_d     = state_q;
    mem_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall_o = pending;
        state_d     = pending ? REQ : IDLE;
      end
      REQ: begin
        mem_stall_o = 1'b1;
        state_d     = (dhit_i | tc) ? DONE : REQ;
      end
      DONE:    state_d = pipe_adv_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      req_q       <= '0;
      load_data_o <= '0;
      halted_o    <= 1'b0;
      conflict_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pending) begin
        req_q      <= '{ren: ~d_wen_i, wen: d_wen_i, addr: word_t'(dmemaddr_i), store: word_t'(dmemstore_i)};
        conflict_o <= conflict_o | (d_ren_i & d_wen_i);
      end
      if (state_q == IDLE && !pending && halt_i) halted_o <= 1'b1;
      // dhit has priority over a same-cycle timeout, so the read still lands
      if (state_q == REQ && (dhit_i || tc)) begin
        req_q.ren <= 1'b0;
        req_q.wen <= 1'b0;
      end
      if (state_q == REQ && dhit_i && req_q.ren) load_data_o <= dmemload_i;
      if (tc) timeout_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl.
module tb_mem_access_ctrl;
  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } exp_req_t;
  localparam int unsigned TO = 4;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        d_ren_i = 1'b0, d_wen_i = 1'b0, halt_i = 1'b0, pipe_adv_i = 1'b0, dhit_i = 1'b0;
  logic [31:0] dmemaddr_i = '0, dmemstore_i = '0, dmemload_i = '0;
  logic        dmemREN_o, dmemWEN_o, mem_stall_o, halted_o, conflict_o, timeout_o;
  logic [31:0] dmemaddr_o, dmemstore_o, load_data_o;
  exp_req_t    req_q[$];
  logic [31:0] load_q[$];
  exp_req_t    cur;
  logic [31:0] last_load = '0;
  int          n_chk = 0, n_fail = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .d_ren_i(d_ren_i), .d_wen_i(d_wen_i),
    .dmemaddr_i(dmemaddr_i), .dmemstore_i(dmemstore_i), .halt_i(halt_i),
    .pipe_adv_i(pipe_adv_i), .dhit_i(dhit_i), .dmemload_i(dmemload_i),
    .dmemREN_o(dmemREN_o), .dmemWEN_o(dmemWEN_o), .dmemaddr_o(dmemaddr_o),
    .dmemstore_o(dmemstore_o), .load_data_o(load_data_o), .mem_stall_o(mem_stall_o),
    .halted_o(halted_o), .conflict_o(conflict_o), .timeout_o(timeout_o)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] s);
    req_q.push_back('{ren: ren, wen: wen, addr: a, store: s});
  endtask

  task automatic pop_req(input string tag);
    n_chk++;
    assert (req_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected one request", tag);
    end
    if (req_q.size() > 0) begin
      cur = req_q.pop_front();
      held_req(tag);
    end
  endtask

  task automatic held_req(input string tag);
    chk({tag, "_ren"}, {31'd0, dmemREN_o}, {31'd0, cur.ren});
    chk({tag, "_wen"}, {31'd0, dmemWEN_o}, {31'd0, cur.wen});
    chk({tag, "_addr"}, dmemaddr_o, cur.addr);
    chk({tag, "_store"}, dmemstore_o, cur.store);
  endtask

  task automatic pop_load(input string tag);
    n_chk++;
    assert (load_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s: observed empty load scoreboard expected one entry", tag);
    end
    if (load_q.size() > 0) last_load = load_q.pop_front();
    chk(tag, load_data_o, last_load);
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_ren"}, {31'd0, dmemREN_o}, 32'd0);
    chk({tag, "_wen"}, {31'd0, dmemWEN_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, mem_stall_o}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ren", {31'd0, dmemREN_o}, 32'd0);
    chk("rst_wen", {31'd0, dmemWEN_o}, 32'd0);
    chk("rst_addr", dmemaddr_o, 32'd0);
    chk("rst_store", dmemstore_o, 32'd0);
    chk("rst_load", load_data_o, 32'd0);
    chk("rst_flags", {29'd0, halted_o, conflict_o, timeout_o}, 32'd0);
    RST = 1'b0;
    #1;
    chk("rst_stall", {31'd0, mem_stall_o}, 32'd0);
    // read, dhit in the first REQ cycle
    d_ren_i = 1'b1; dmemaddr_i = 32'h0000_0040; dmemstore_i = 32'h0BAD_0BAD;
    push_req(1'b1, 1'b0, 32'h0000_0040, 32'h0BAD_0BAD);
    #1;
    chk("rd_idle_stall", {31'd0, mem_stall_o}, 32'd1);
    tick();
    pop_req("rd_req");
    chk("rd_req_stall", {31'd0, mem_stall_o}, 32'd1);
    d_ren_i = 1'b0; dhit_i = 1'b1; dmemload_i = 32'hDEAD_BEEF;
    load_q.push_back(32'hDEAD_BEEF);
    tick();
    dhit_i = 1'b0;
    idle_outputs("rd_done");
    pop_load("rd_load");
    pipe_adv_i = 1'b1;
    tick();
    pipe_adv_i = 1'b0;
    #1;
    idle_outputs("rd_back_idle");
    // write, four REQ cycles with inputs disturbed mid-request
    d_wen_i = 1'b1; dmemaddr_i = 32'h0000_0080; dmemstore_i = 32'h1234_5678;
    push_req(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678);
    tick();
    pop_req("wr_req1");
    d_wen_i = 1'b0; d_ren_i = 1'b1; dmemaddr_i = 32'h0000_FFFF; dmemstore_i = 32'h0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      held_req($sformatf("wr_req%0d", i));
      chk($sformatf("wr_stall%0d", i), {31'd0, mem_stall_o}, 32'd1);
    end
    dhit_i = 1'b1; dmemload_i = 32'hAAAA_5555;
    tick();
    dhit_i = 1'b0;
    chk("wr_load_kept", load_data_o, last_load);
    // DONE held by another hazard while a read sits on the inputs
    for (int i = 0; i < 3; i++) begin
      idle_outputs($sformatf("done_hold%0d", i));
      tick();
    end
    idle_outputs("done_hold3");
    d_ren_i = 1'b0; pipe_adv_i = 1'b1;
    tick();
    pipe_adv_i = 1'b0;
    #1;
    idle_outputs("done_idle");
    // simultaneous read and write: write wins and conflict sticks
    d_ren_i = 1'b1; d_wen_i = 1'b1; dmemaddr_i = 32'h0000_0100; dmemstore_i = 32'hCAFE_F00D;
    push_req(1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D);
    tick();
    d_ren_i = 1'b0; d_wen_i = 1'b0;
    pop_req("cf_req");
    chk("cf_flag", {31'd0, conflict_o}, 32'd1);
    dhit_i = 1'b1;
    tick();
    dhit_i = 1'b0; pipe_adv_i = 1'b1;
    tick();
    pipe_adv_i = 1'b0;
    halt_i = 1'b1;
    #1;
    chk("halt_stall", {31'd0, mem_stall_o}, 32'd0);
    tick();
    halt_i = 1'b0;
    chk("halt_flag", {31'd0, halted_o}, 32'd1);
    d_ren_i = 1'b1; dmemaddr_i = 32'h0000_0200;
    #1;
    chk("halt_no_stall", {31'd0, mem_stall_o}, 32'd0);
    tick();
    tick();
    idle_outputs("halt_no_req");
    chk("halt_sticky", {30'd0, halted_o, conflict_o}, 32'd3);
    // reset during the second REQ cycle discards the request
    d_ren_i = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst2_flags", {29'd0, halted_o, conflict_o, timeout_o}, 32'd0);
    d_ren_i = 1'b1; dmemaddr_i = 32'h0000_0300; dmemstore_i = 32'h0;
    push_req(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    tick();
    d_ren_i = 1'b0;
    pop_req("mr_req1");
    tick();
    held_req("mr_req2");
    RST = 1'b1;
    tick();
    RST = 1'b0;
    idle_outputs("mr_after_rst");
    chk("mr_load", load_data_o, 32'd0);
    chk("mr_flags", {29'd0, halted_o, conflict_o, timeout_o}, 32'd0);
    dhit_i = 1'b1; dmemload_i = 32'h1111_2222;
    tick();
    dhit_i = 1'b0;
    idle_outputs("mr_dhit_ignored");
    chk("mr_dhit_load", load_data_o, 32'd0);
    // fresh read proves the controller is back in IDLE
    d_ren_i = 1'b1; dmemaddr_i = 32'h0000_0044; dmemstore_i = 32'h0;
    push_req(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    #1;
    chk("post_rst_stall", {31'd0, mem_stall_o}, 32'd1);
    tick();
    d_ren_i = 1'b0;
    pop_req("post_rst_req");
    dhit_i = 1'b1; dmemload_i = 32'h5A5A_A5A5;
    load_q.push_back(32'h5A5A_A5A5);
    tick();
    dhit_i = 1'b0;
    pop_load("post_rst_load");
    pipe_adv_i = 1'b1;
    tick();
    pipe_adv_i = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    d_ren_i = 1'b1; dmemaddr_i = 32'h0000_0500;
    push_req(1'b1, 1'b0, 32'h0000_0500, 32'h0);
    tick();
    d_ren_i = 1'b0;
    pop_req("to_req1");
    for (int i = 2; i <= int'(TO); i++) begin
      tick();
      held_req($sformatf("to_req%0d", i));
    end
    tick();
    idle_outputs("to_done");
    chk("to_flag", {31'd0, timeout_o}, 32'd1);
    chk("to_load_kept", load_data_o, last_load);
`else
    chk("no_timeout", {31'd0, timeout_o}, 32'd0);
`endif
    chk("sb_req_empty", req_q.size(), 32'd0);
    chk("sb_load_empty", load_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
